instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 6 +
 rtl/instr_fetch_if.sv | 21 ++
 rtl/instr_fetch.sv | 62 ++++++
 tb/tb_instr_fetch.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants.
package mips_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} fetch_state_t;
   localparam int INSTR_W = 32;
   localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and decode-side handshake bundle of the fetch stage.
interface instr_fetch_if;
   import mips_pkg::*;
   logic imem_req;
   logic [31:0] imem_addr;
   logic imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic if_valid;
   logic if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
      input imem_ack, imem_rdata, if_ready
   );
   modport slave (
      input imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
      output imem_ack, imem_rdata, if_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM driving next_pc, the imem request and the decode-side instruction register.
module instr_fetch import mips_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic clk,
   input  logic reset,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   input  logic redirect,
   input  logic [31:0] redirect_pc,
   instr_fetch_if.master bus
);
   fetch_state_t state, state_nx;
   logic [31:0] pend_pc, pc4, npc;
   logic take;
   assign pc4 = pc + PC_INC;
   always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = REQ;
         REQ:  state_nx = bus.imem_ack ? (redirect ? REQ : HOLD) : (redirect ? DROP : REQ);
         DROP: state_nx = bus.imem_ack ? REQ : DROP;
         HOLD: state_nx = (redirect || (bus.if_valid && bus.if_ready)) ? REQ : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   // Data returned alongside a redirect, or for an abandoned request, is never captured.
   always_comb begin
      take = state == REQ && bus.imem_ack && !redirect;
      bus.imem_req = state == REQ || state == DROP;
      bus.imem_addr = pc;
      npc = pc;
      case (state)
         IDLE, HOLD: npc = redirect ? redirect_pc : pc;
         REQ:  npc = (redirect && bus.imem_ack) ? redirect_pc : take ? pc4 : pc;
         DROP: npc = bus.imem_ack ? (redirect ? redirect_pc : pend_pc) : pc;
         default: npc = pc;
      endcase
      if (reset) npc = RESET_PC;
      next_pc = {npc[31:2], 2'b00};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.if_valid <= 1'b0;
         bus.if_instr <= '0;
         bus.if_pc <= '0;
         bus.if_pc4 <= '0;
         pend_pc <= '0;
      end else begin
         if (take) begin
            bus.if_valid <= 1'b1;
            bus.if_instr <= bus.imem_rdata;
            bus.if_pc <= pc;
            bus.if_pc4 <= pc4;
         end else if (redirect || (state == HOLD && bus.if_ready)) begin
            bus.if_valid <= 1'b0;
         end
         if (redirect && ((state == REQ && !bus.imem_ack) || state == DROP)) pend_pc <= redirect_pc;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic checked against a program-order model.
module tb_instr_fetch;
   import mips_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc, next_pc;
   int checks = 0;
   int failures = 0;
   instr_fetch_if bus();
   instr_fetch #(.RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
   );
   always #5 clk = ~clk;
   always_ff @(posedge clk) pc <= next_pc;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction
   initial begin
      logic [31:0] exp_pc, s_pc, s_instr;
      logic [1:0] lo;
      logic prev_redir, prev_hold, hold;
      int xfers;
      bus.imem_ack = 0;
      bus.imem_rdata = 0;
      bus.if_ready = 0;
      #1 chk("reset_next_pc", next_pc, 32'h0);
      tick(); reset = 0; #1;
      chk("rst_valid", bus.if_valid, 0);
      chk("rst_instr", bus.if_instr, 0);
      chk("rst_pc4", bus.if_pc4, 0);
      chk("rst_req", bus.imem_req, 0);
      chk("rst_pc", pc, 0);
      tick();
      chk("req0_req", bus.imem_req, 1);
      chk("req0_addr", bus.imem_addr, 0);
      chk("req0_npc", next_pc, 0);
      tick(); bus.imem_ack = 1; bus.imem_rdata = 32'h2008_0005; #1;
      chk("ack0_npc", next_pc, 32'h4);
      tick(); bus.imem_ack = 0; #1;
      chk("first_valid", bus.if_valid, 1);
      chk("first_instr", bus.if_instr, 32'h2008_0005);
      chk("first_pc", bus.if_pc, 0);
      chk("first_pc4", bus.if_pc4, 32'h4);
      chk("first_pcreg", pc, 32'h4);
      for (int i = 0; i < 3; i++) begin
         chk("hold_instr", bus.if_instr, 32'h2008_0005);
         chk("hold_valid", bus.if_valid, 1);
         chk("hold_req", bus.imem_req, 0);
         chk("hold_npc", next_pc, 32'h4);
         tick();
      end
      bus.if_ready = 1; #1;
      tick(); bus.if_ready = 0; #1;
      chk("rel_req", bus.imem_req, 1);
      chk("rel_addr", bus.imem_addr, 32'h4);
      chk("rel_valid", bus.if_valid, 0);
      bus.imem_ack = 1; bus.imem_rdata = 32'h1111_1111; #1;
      tick(); bus.imem_ack = 0; bus.if_ready = 1; #1;
      chk("second_pc", bus.if_pc, 32'h4);
      tick(); bus.if_ready = 0;
      redirect = 1; redirect_pc = 32'h40; #1;
      chk("drop_addr0", bus.imem_addr, 32'h8);
      chk("drop_npc0", next_pc, 32'h8);
      tick(); redirect = 0; #1;
      chk("drop_req", bus.imem_req, 1);
      chk("drop_addr1", bus.imem_addr, 32'h8);
      chk("drop_npc1", next_pc, 32'h8);
      tick(); bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF; #1;
      chk("drop_addr2", bus.imem_addr, 32'h8);
      chk("drop_npc2", next_pc, 32'h40);
      tick(); bus.imem_ack = 0; #1;
      chk("drop_valid", bus.if_valid, 0);
      chk("drop_next_addr", bus.imem_addr, 32'h40);
      chk("drop_next_req", bus.imem_req, 1);
      bus.imem_ack = 1; redirect = 1; redirect_pc = 32'h100; #1;
      chk("coinc_npc", next_pc, 32'h100);
      tick(); bus.imem_ack = 0; redirect = 0; #1;
      chk("coinc_valid", bus.if_valid, 0);
      chk("coinc_addr", bus.imem_addr, 32'h100);
      chk("coinc_req", bus.imem_req, 1);
      bus.imem_ack = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFC; #1;
      tick(); bus.imem_ack = 0; redirect = 0; #1;
      chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      bus.imem_ack = 1; bus.imem_rdata = 32'hCAFE_0001; #1;
      chk("wrap_npc", next_pc, 32'h0);
      tick(); bus.imem_ack = 0; #1;
      chk("wrap_valid", bus.if_valid, 1);
      chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
      chk("wrap_if_pc4", bus.if_pc4, 32'h0);
      chk("wrap_pcreg", pc, 32'h0);
      redirect = 1; redirect_pc = 32'h103; #1;
      chk("align_npc", next_pc, 32'h100);
      tick(); redirect = 0; #1;
      chk("hold_redir_valid", bus.if_valid, 0);
      chk("hold_redir_addr", bus.imem_addr, 32'h100);
      reset = 1; bus.imem_ack = 1; #1;
      chk("midrst_npc", next_pc, 32'h0);
      tick(); reset = 0; bus.imem_ack = 0; #1;
      chk("midrst_req", bus.imem_req, 0);
      chk("midrst_valid", bus.if_valid, 0);
      chk("midrst_if_pc", bus.if_pc, 0);
      chk("midrst_pc", pc, 0);
      tick();
      chk("restart_req", bus.imem_req, 1);
      chk("restart_addr", bus.imem_addr, 0);
      reset = 1; tick(); reset = 0;
      exp_pc = 32'h0; prev_redir = 0; prev_hold = 0; xfers = 0; s_pc = 0; s_instr = 0;
      for (int n = 0; n < 3000; n++) begin
         redirect = ($urandom % 8) == 0;
         redirect_pc = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom % 512;
         bus.if_ready = $urandom % 2;
         bus.imem_ack = bus.imem_req && ($urandom % 3 == 0);
         bus.imem_rdata = mem(pc);
         #1;
         if (prev_redir) chk("r_redir_clears", bus.if_valid, 0);
         if (prev_hold) begin
            chk("r_hold_valid", bus.if_valid, 1);
            chk("r_hold_pc", bus.if_pc, s_pc);
            chk("r_hold_instr", bus.if_instr, s_instr);
         end
         if (bus.imem_req) chk("r_addr", bus.imem_addr, pc);
         lo = next_pc[1:0];
         chk("r_align", {30'b0, lo}, 0);
         chk("r_req_vs_valid", bus.imem_req & bus.if_valid, 0);
         if (bus.if_valid) begin
            chk("r_instr", bus.if_instr, mem(bus.if_pc));
            chk("r_pc4", bus.if_pc4, bus.if_pc + 32'd4);
         end
         hold = bus.if_valid && !bus.if_ready && !redirect;
         if (hold) chk("r_hold_npc", next_pc, pc);
         if (bus.if_valid && bus.if_ready) begin
            chk("r_order", bus.if_pc, exp_pc);
            exp_pc = bus.if_pc + 32'd4;
            xfers++;
         end
         if (redirect) exp_pc = redirect_pc & ~32'd3;
         prev_redir = redirect;
         prev_hold = hold;
         s_pc = bus.if_pc;
         s_instr = bus.if_instr;
         tick();
      end
      redirect = 0; bus.imem_ack = 0; bus.if_ready = 0;
      chk("r_progress", {31'b0, xfers >= 100}, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
